// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: PC select codes, NOP word, FSM states.
package fetch_pkg;

  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_JAL    = 2'b01;
  localparam logic [1:0] PCSEL_JALR   = 2'b10;
  localparam logic [1:0] PCSEL_BRANCH = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HELD  = 2'b01,
    REDIR = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Next-PC selection: sequential PC+4 or one of the decode-supplied redirect targets.
module pc_next_mux
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_jal_tgt,
  input  logic [31:0] i_jalr_tgt,
  input  logic [31:0] i_br_tgt,
  output logic [31:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc + 32'd4;
    case (i_pc_sel)
      PCSEL_JAL:    o_pc_next = i_jal_tgt;
      PCSEL_JALR:   o_pc_next = i_jalr_tgt & ~32'h0000_0001;
      PCSEL_BRANCH: o_pc_next = i_br_tgt;
      default:      o_pc_next = i_pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, synchronous IMEM interface, skid buffer and F/D register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_jal_tgt,
  input  logic [31:0] i_jalr_tgt,
  input  logic [31:0] i_br_tgt,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_rd,
  input  logic [31:0] i_imem_data,
  output logic [4:0]  o_f_addr1,
  output logic [4:0]  o_f_addr2,
  output logic [4:0]  o_f_waddr,
  output logic [6:0]  o_f_op,
  output logic [31:0] o_d_pc,
  output logic [31:0] o_d_instr,
  output logic        o_d_valid
);

  fetch_state_e r_state, w_state_next;

  logic [31:0] r_pc, r_f_pc, r_skid, r_d_pc, r_d_instr;
  logic        r_f_valid, r_skid_valid, r_d_valid;
  logic [31:0] w_pc_next, w_fetch_word;
  logic        w_redirect, w_advance, w_skid_load, w_skid_clr;

  pc_next_mux u_pc_next_mux (
    .i_pc       (r_pc),
    .i_pc_sel   (i_pc_sel),
    .i_jal_tgt  (i_jal_tgt),
    .i_jalr_tgt (i_jalr_tgt),
    .i_br_tgt   (i_br_tgt),
    .o_pc_next  (w_pc_next)
  );

  assign w_redirect   = (i_pc_sel != PCSEL_PLUS4);
  assign w_fetch_word = r_skid_valid ? r_skid : i_imem_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_next;
  end

  // Stall dominates; a redirect is only acted on once the stall has dropped.
  always_comb begin
    w_state_next = RUN;
    if (i_stall)         w_state_next = HELD;
    else if (w_redirect) w_state_next = REDIR;
  end

  always_comb begin
    w_advance   = !i_stall;
    w_skid_load = i_stall && r_f_valid && !r_skid_valid;
    case (r_state)
      HELD:    w_skid_clr = !i_stall;
      default: w_skid_clr = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_f_pc       <= RESET_PC;
      r_f_valid    <= 1'b0;
      r_skid       <= 32'h0;
      r_skid_valid <= 1'b0;
      r_d_pc       <= 32'h0;
      r_d_instr    <= NOP;
      r_d_valid    <= 1'b0;
    end else begin
      if (w_skid_load) begin
        r_skid       <= i_imem_data;
        r_skid_valid <= 1'b1;
      end else if (w_skid_clr) begin
        r_skid_valid <= 1'b0;
      end
      if (w_advance) begin
        r_pc      <= w_pc_next;
        r_f_pc    <= r_pc;
        r_f_valid <= !w_redirect;   // word for the old PC is wrong-path
        r_d_pc    <= r_f_pc;
        if (i_flush) begin
          r_d_instr <= NOP;
          r_d_valid <= 1'b0;
        end else begin
          r_d_instr <= w_fetch_word;
          r_d_valid <= r_f_valid;
        end
      end
    end
  end

  assign o_imem_addr = r_pc;
  assign o_imem_rd   = i_rst_n && !i_stall;

  assign o_f_addr1 = r_f_valid ? w_fetch_word[19:15] : 5'd0;
  assign o_f_addr2 = r_f_valid ? w_fetch_word[24:20] : 5'd0;
  assign o_f_waddr = r_f_valid ? w_fetch_word[11:7]  : 5'd0;
  assign o_f_op    = r_f_valid ? w_fetch_word[6:0]   : 7'd0;

  assign o_d_pc    = r_d_pc;
  assign o_d_instr = r_d_instr;
  assign o_d_valid = r_d_valid;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 5-stage I-core pipeline: owns the PC register, drives the synchronous instruction memory, and produces the F/D pipeline register. It consumes the hazard unit's STALL, FLUSH and PC_SEL outputs. It also returns the fetch-stage register-address and opcode fields (F_ADDR1/F_ADDR2/F_WADDR/F_OP) that the hazard unit compares. A skid register preserves the in-flight IMEM word across stalls.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- CLK  in  1  pipeline clock, all state on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- STALL  in  1  hold F and D (load-use); highest priority.
- FLUSH  in  1  insert bubble into D on next edge.
- PC_SEL  in  2  00 PC+4, 01 JAL, 10 JALR, 11 BRANCH.
- JAL_TGT / JALR_TGT / BR_TGT  in  32 each  redirect targets from decode; JALR_TGT bit 0 is forced to 0.
- IMEM_ADDR  out  32  fetch address (= PC register).
- IMEM_RD  out  1  read strobe.
- IMEM_DATA  in  32  word for the address presented the previous cycle.
- F_ADDR1 / F_ADDR2 / F_WADDR  out  5 each  instr[19:15] / [24:20] / [11:7] of the fetch word; 0 when not valid.
- F_OP  out  7  instr[6:0] of the fetch word; 0 when not valid.
- D_PC  out  32  PC of the decode instruction.
- D_INSTR  out  32  decode instruction word.
- D_VALID  out  1  decode slot holds a real instruction.

## Operation
- Internal state:
  - PC: next address to issue.
  - f_pc / f_valid: address issued last cycle, and whether it is live.
  - skid / skid_valid: captured IMEM word.
  - 3-state FSM: RUN, HELD, REDIR.
- Fetch word = skid when skid_valid, else IMEM_DATA; fetch valid = f_valid.
- RUN, no STALL:
  - D loads {f_pc, fetch word, f_valid}.
  - PC <= next PC per PC_SEL.
  - f_pc <= PC, f_valid <= 1.
- STALL, any state:
  - PC, f_pc and D hold; IMEM_RD = 0.
  - If f_valid and !skid_valid, skid <= IMEM_DATA and skid_valid <= 1.
  - FSM -> HELD.
- HELD with STALL low:
  - Behaves as RUN, using the skid word.
  - skid_valid <= 0; FSM -> RUN.
- Redirect (PC_SEL != 00, no STALL):
  - PC <= selected target; D loads as normal.
  - The word for the old PC (wrong path) is squashed: f_valid <= 0, skid_valid <= 0.
  - FSM -> REDIR for exactly one cycle, then RUN.
- FLUSH without STALL:
  - D_VALID <= 0, D_INSTR <= NOP (32'h0000_0013), D_PC <= f_pc.
  - F proceeds normally.
- Simultaneous events:
  - STALL beats FLUSH and beats a redirect; the redirect is re-evaluated on the cycle STALL drops.
  - FLUSH with a redirect: both apply.
- Next PC is computed modulo 2^32; PC+4 wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset values:
  - PC = RESET_PC, IMEM_ADDR = RESET_PC, IMEM_RD = 0.
  - f_valid = 0, skid_valid = 0, FSM = RUN.
  - D_PC = 0, D_INSTR = NOP, D_VALID = 0; F_* = 0.
- IMEM_RD = RST_N synchronised high and !STALL.
- Latency and throughput:
  - First D_VALID = 1 is 2 edges after reset release.
  - Steady state: one instruction per cycle.
- Redirect penalty: one bubble in D (D_VALID = 0); target instruction reaches D 2 edges after the redirect edge.
- Stall release: the skid word enters D on the first edge with STALL low; no IMEM re-read, no lost or duplicated instruction.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately; skid is discarded.

## Structure
- Shared package fetch_pkg:
  - PC_SEL encodings: PCSEL_PLUS4, PCSEL_JAL, PCSEL_JALR, PCSEL_BRANCH.
  - NOP constant 32'h0000_0013.
  - FSM enum: RUN, HELD, REDIR.
- Opcodes remain in opcodes.svh.
- One sub-module, pc_next_mux: combinational PC+4 / target select with JALR bit-0 clear.
- All sequential logic stays in fetch_unit.

## Test plan
- Reset release, IMEM returns 0x00500093, 0x00A00113 -> D_VALID=1 with D_PC=0, D_INSTR=0x00500093 on edge 2; D_PC=4 on edge 3.
- STALL for 2 cycles while IMEM word 0x0000A183 is in flight -> D held, IMEM_RD=0, word emerges from skid into D with correct PC; no duplicate.
- PC_SEL=01, JAL_TGT=0x100 -> one bubble (D_VALID=0), then D_PC=0x100; wrong-path word never reaches D_VALID=1.
- PC_SEL=10, JALR_TGT=0x203 -> IMEM_ADDR=0x202.
- STALL and PC_SEL=11 together -> PC holds; redirect to BR_TGT taken on the first cycle STALL is low.
- FLUSH pulse -> D_INSTR=0x00000013, D_VALID=0 for one cycle, fetch continues sequentially; RST_N low mid-stall -> all outputs at reset values asynchronously.
